// File: rtl/adpll_lock_controller.sv
// Acquisition and lock sequencer for the ADPLL.
// Runs a successive-approximation search on the phase-accumulator bias using the
// sign of averaged phase-detector error. It then enables the loop filter and
// tracks lock from the error magnitude. Sustained saturation restarts acquisition.
//
// Handshake: error_valid_i is a one-cycle qualifier with no back-pressure.
// error_i is consumed only on cycles where error_valid_i is high, and only in
// COARSE, TRACK or LOCKED. The block is always ready.
module adpll_lock_controller #(
    parameter int ACCUM_WIDTH  = 12,
    parameter int PDET_WIDTH   = 8,
    parameter int SAR_BITS     = 8,
    parameter int AVG_SAMPLES  = 16,
    parameter int LOCK_TOL     = 2,
    parameter int LOCK_COUNT   = 32,
    parameter int UNLOCK_COUNT = 4,
    parameter int FAIL_COUNT   = 64
) (
    input  logic                   fpga_clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [PDET_WIDTH-1:0]  error_i,
    input  logic                   error_valid_i,
    output logic [ACCUM_WIDTH-1:0] k_bias_o,
    output logic                   loop_en_o,
    output logic                   lock_o,
    output logic [2:0]             state_o,
    output logic [7:0]             relock_cnt_o
);

    localparam int AVG_W    = $clog2(AVG_SAMPLES);
    localparam int SUM_W    = PDET_WIDTH + AVG_W;
    localparam int ABS_W    = PDET_WIDTH + 1;
    localparam int BIT_W    = (SAR_BITS > 1) ? $clog2(SAR_BITS) : 1;
    localparam int LOCK_W   = $clog2(LOCK_COUNT + 1);
    localparam int UNLOCK_W = $clog2(UNLOCK_COUNT + 1);
    localparam int FAIL_W   = $clog2(FAIL_COUNT + 1);

    localparam logic [ACCUM_WIDTH-1:0] SAR_ONE     = ACCUM_WIDTH'(1);
    localparam logic [ACCUM_WIDTH-1:0] SAR_START   = SAR_ONE << (SAR_BITS - 1);
    localparam logic [BIT_W-1:0]       BIT_TOP     = BIT_W'(SAR_BITS - 1);
    localparam logic [AVG_W-1:0]       AVG_LAST    = AVG_W'(AVG_SAMPLES - 1);
    localparam logic [LOCK_W-1:0]      LOCK_LAST   = LOCK_W'(LOCK_COUNT - 1);
    localparam logic [UNLOCK_W-1:0]    UNLOCK_LAST = UNLOCK_W'(UNLOCK_COUNT - 1);
    localparam logic [FAIL_W-1:0]      FAIL_LAST   = FAIL_W'(FAIL_COUNT - 1);
    localparam logic [PDET_WIDTH-1:0]  SAT_NEG     = {1'b1, {(PDET_WIDTH-1){1'b0}}};
    localparam logic [PDET_WIDTH-1:0]  SAT_POS     = {1'b0, {(PDET_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COARSE = 3'd1,
        ST_TRACK  = 3'd2,
        ST_LOCKED = 3'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ACCUM_WIDTH-1:0] k_bias_q, k_bias_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic [AVG_W-1:0]       sample_cnt_q, sample_cnt_d;
    logic [LOCK_W-1:0]      lock_cnt_q, lock_cnt_d;
    logic [UNLOCK_W-1:0]    unlock_cnt_q, unlock_cnt_d;
    logic [FAIL_W-1:0]      fail_cnt_q, fail_cnt_d;
    logic                   lock_q, lock_d;
    logic                   loop_en_q, loop_en_d;
    logic [7:0]             relock_q, relock_d;

    // Error-derived terms: sign-extended sample, running sum including this
    // sample, magnitude in one extra bit so the most negative code cannot wrap.
    logic [SUM_W-1:0] err_sext;
    logic [SUM_W-1:0] sum_next;
    logic [ABS_W-1:0] err_ext;
    logic [ABS_W-1:0] err_abs;
    logic             in_tol;
    logic             saturated;

    assign err_sext  = {{AVG_W{error_i[PDET_WIDTH-1]}}, error_i};
    assign sum_next  = sum_q + err_sext;
    assign err_ext   = {error_i[PDET_WIDTH-1], error_i};
    assign err_abs   = err_ext[ABS_W-1] ? (~err_ext + ABS_W'(1)) : err_ext;
    assign in_tol    = (err_abs <= ABS_W'(LOCK_TOL));
    assign saturated = (error_i == SAT_NEG) || (error_i == SAT_POS);

    // Next-state and next-output logic; later assignments override earlier ones,
    // so the saturation restart is evaluated after the lock/unlock transitions.
    always_comb begin
        state_d      = state_q;
        k_bias_d     = k_bias_q;
        bit_idx_d    = bit_idx_q;
        sum_d        = sum_q;
        sample_cnt_d = sample_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        unlock_cnt_d = unlock_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        lock_d       = lock_q;
        loop_en_d    = loop_en_q;
        relock_d     = relock_q;

        if (!enable_i) begin
            state_d      = ST_IDLE;
            k_bias_d     = '0;
            bit_idx_d    = '0;
            sum_d        = '0;
            sample_cnt_d = '0;
            lock_cnt_d   = '0;
            unlock_cnt_d = '0;
            fail_cnt_d   = '0;
            lock_d       = 1'b0;
            loop_en_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_COARSE;
                    k_bias_d     = SAR_START;
                    bit_idx_d    = BIT_TOP;
                    sum_d        = '0;
                    sample_cnt_d = '0;
                end
                ST_COARSE: begin
                    if (error_valid_i) begin
                        if (sample_cnt_q == AVG_LAST) begin
                            // Negative average: generated clock too fast, drop the trial bit.
                            if (sum_next[SUM_W-1]) begin
                                k_bias_d = k_bias_q & ~(SAR_ONE << bit_idx_q);
                            end
                            sum_d        = '0;
                            sample_cnt_d = '0;
                            if (bit_idx_q == '0) begin
                                state_d      = ST_TRACK;
                                loop_en_d    = 1'b1;
                                lock_cnt_d   = '0;
                                unlock_cnt_d = '0;
                                fail_cnt_d   = '0;
                            end else begin
                                bit_idx_d = bit_idx_q - BIT_W'(1);
                                k_bias_d  = k_bias_d | (SAR_ONE << (bit_idx_q - BIT_W'(1)));
                            end
                        end else begin
                            sum_d        = sum_next;
                            sample_cnt_d = sample_cnt_q + AVG_W'(1);
                        end
                    end
                end
                ST_TRACK, ST_LOCKED: begin
                    if (error_valid_i) begin
                        if (state_q == ST_TRACK) begin
                            if (!in_tol) begin
                                lock_cnt_d = '0;
                            end else if (lock_cnt_q == LOCK_LAST) begin
                                state_d      = ST_LOCKED;
                                lock_d       = 1'b1;
                                lock_cnt_d   = '0;
                                unlock_cnt_d = '0;
                            end else begin
                                lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                            end
                        end else begin
                            if (in_tol) begin
                                unlock_cnt_d = '0;
                            end else if (unlock_cnt_q == UNLOCK_LAST) begin
                                state_d      = ST_TRACK;
                                lock_d       = 1'b0;
                                lock_cnt_d   = '0;
                                unlock_cnt_d = '0;
                            end else begin
                                unlock_cnt_d = unlock_cnt_q + UNLOCK_W'(1);
                            end
                        end

                        if (!saturated) begin
                            fail_cnt_d = '0;
                        end else if (fail_cnt_q == FAIL_LAST) begin
                            // Loop has railed for too long: restart the coarse search.
                            state_d      = ST_COARSE;
                            k_bias_d     = SAR_START;
                            bit_idx_d    = BIT_TOP;
                            sum_d        = '0;
                            sample_cnt_d = '0;
                            lock_cnt_d   = '0;
                            unlock_cnt_d = '0;
                            fail_cnt_d   = '0;
                            lock_d       = 1'b0;
                            loop_en_d    = 1'b0;
                            if (relock_q != 8'hFF) begin
                                relock_d = relock_q + 8'd1;
                            end
                        end else begin
                            fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    k_bias_d  = '0;
                    lock_d    = 1'b0;
                    loop_en_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; synchronous reset dominates all inputs.
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            k_bias_q     <= '0;
            bit_idx_q    <= '0;
            sum_q        <= '0;
            sample_cnt_q <= '0;
            lock_cnt_q   <= '0;
            unlock_cnt_q <= '0;
            fail_cnt_q   <= '0;
            lock_q       <= 1'b0;
            loop_en_q    <= 1'b0;
            relock_q     <= '0;
        end else begin
            state_q      <= state_d;
            k_bias_q     <= k_bias_d;
            bit_idx_q    <= bit_idx_d;
            sum_q        <= sum_d;
            sample_cnt_q <= sample_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            lock_q       <= lock_d;
            loop_en_q    <= loop_en_d;
            relock_q     <= relock_d;
        end
    end

    assign k_bias_o     = k_bias_q;
    assign loop_en_o    = loop_en_q;
    assign lock_o       = lock_q;
    assign state_o      = state_q;
    assign relock_cnt_o = relock_q;

endmodule

// File: tb/tb_adpll_lock_controller.sv
// Directed-sequence bench for adpll_lock_controller with randomized error
// values and sample spacing. Expected SAR results come from an arithmetic
// model of the search (sum the errors the bench itself generated per trial).
module tb_adpll_lock_controller;

    localparam int ACCUM_WIDTH = 12;
    localparam int PDET_WIDTH  = 8;
    localparam int SAR_BITS    = 8;
    localparam int AVG_SAMPLES = 16;

    logic                   clk = 1'b0;
    logic                   reset_i;
    logic                   enable_i;
    logic [PDET_WIDTH-1:0]  error_i;
    logic                   error_valid_i;
    logic [ACCUM_WIDTH-1:0] k_bias_o;
    logic                   loop_en_o;
    logic                   lock_o;
    logic [2:0]             state_o;
    logic [7:0]             relock_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_relock = 0;
    int sar_res;

    // Clock
    always #5 clk = ~clk;

    adpll_lock_controller dut (
        .fpga_clk_i    (clk),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .error_i       (error_i),
        .error_valid_i (error_valid_i),
        .k_bias_o      (k_bias_o),
        .loop_en_o     (loop_en_o),
        .lock_o        (lock_o),
        .state_o       (state_o),
        .relock_cnt_o  (relock_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (failure #%0d)", tag, obs, exp, n_fail);
        end
    endtask

    task automatic check_outs(input string tag, input int st, input int k,
                              input int loop_en, input int lock);
        check({tag, "_state"},  state_o,      st);
        check({tag, "_k"},      k_bias_o,     k);
        check({tag, "_loop"},   loop_en_o,    loop_en);
        check({tag, "_lock"},   lock_o,       lock);
        check({tag, "_relock"}, relock_cnt_o, exp_relock);
    endtask

    // Driver: random idle gap, one valid pulse, then garbage on error_i.
    // Returns at the following negedge, after the DUT has consumed the sample.
    task automatic send_sample(input int err, input logic en);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        error_i       = err[7:0];
        error_valid_i = 1'b1;
        enable_i      = en;
        @(negedge clk);
        error_valid_i = 1'b0;
        error_i       = 8'($urandom);
    endtask

    task automatic start_search();
        enable_i = 1'b1;
        @(negedge clk);
        check_outs("start", 1, 128, 0, 0);
    endtask

    task automatic go_idle();
        enable_i = 1'b0;
        @(negedge clk);
        check_outs("idle", 0, 0, 0, 0);
    endtask

    // Model of the coarse search: each trial adds the next bit, its 16 errors are
    // summed, and the bit survives when that sum is non-negative.
    task automatic run_sar(input bit const_mode, input int val, input int noise, output int result);
        int res;
        int trial;
        int sum;
        int e;
        res = 0;
        for (int b = SAR_BITS - 1; b >= 0; b--) begin
            trial = res | (1 << b);
            sum = 0;
            for (int s = 0; s < AVG_SAMPLES; s++) begin
                if (const_mode) e = val;
                else begin
                    e = val - trial;
                    if (noise > 0) e = e + int'($urandom_range(0, 2 * noise)) - noise;
                end
                if (e > 127) e = 127;
                if (e < -128) e = -128;
                sum += e;
                send_sample(e, 1'b1);
                if (s < AVG_SAMPLES - 1) begin
                    check("sar_k_hold", k_bias_o, trial);
                    check("sar_state_hold", state_o, 1);
                end
            end
            if (sum >= 0) res = trial;
            if (b > 0) begin
                check("sar_k_step", k_bias_o, res | (1 << (b - 1)));
                check("sar_state_step", state_o, 1);
                check("sar_loop_step", loop_en_o, 0);
            end else begin
                check_outs("sar_done", 2, res, 1, 0);
            end
        end
        result = res;
    endtask

    function automatic int rand_in_tol();
        return int'($urandom_range(0, 4)) - 2;
    endfunction

    function automatic int rand_out_tol();
        int v;
        v = int'($urandom_range(3, 126));
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    // 32 in-tolerance samples from a cleared count: LOCKED on the last one.
    task automatic lock_up(input string tag);
        for (int i = 0; i < 32; i++) begin
            send_sample(rand_in_tol(), 1'b1);
            check({tag, "_lock_state"}, state_o, (i < 31) ? 2 : 3);
            check({tag, "_lock_out"}, lock_o, (i < 31) ? 0 : 1);
        end
    endtask

    // Saturated samples from LOCKED: drops to TRACK after 4, restarts after 64.
    task automatic saturate(input string tag, input int val);
        for (int i = 1; i <= 64; i++) begin
            send_sample(val, 1'b1);
            if (i == 64) exp_relock++;
            check({tag, "_state"}, state_o, (i < 4) ? 3 : ((i < 64) ? 2 : 1));
            check({tag, "_lock"}, lock_o, (i < 4) ? 1 : 0);
            check({tag, "_loop"}, loop_en_o, (i < 64) ? 1 : 0);
        end
        check_outs({tag, "_restart"}, 1, 128, 0, 0);
    endtask

    // Directed sequence
    initial begin
        // Reset held with enable and a valid sample present
        reset_i       = 1'b1;
        enable_i      = 1'b1;
        error_valid_i = 1'b1;
        error_i       = 8'd50;
        repeat (3) @(negedge clk);
        check_outs("reset", 0, 0, 0, 0);
        reset_i       = 1'b0;
        enable_i      = 1'b0;
        error_valid_i = 1'b0;
        @(negedge clk);
        check_outs("post_reset", 0, 0, 0, 0);

        // Constant positive error keeps every bit
        start_search();
        run_sar(1'b1, 10, 0, sar_res);
        check("const_pos_k", k_bias_o, 255);

        // Linear error model with zero crossing at 76
        go_idle();
        start_search();
        run_sar(1'b0, 76, 0, sar_res);
        check("target76_k", k_bias_o, 76);

        // Lock count broken by one out-of-tolerance sample, then rebuilt
        for (int i = 0; i < 20; i++) begin
            send_sample(rand_in_tol(), 1'b1);
            check("pre_break_state", state_o, 2);
        end
        send_sample(rand_out_tol(), 1'b1);
        check("break_state", state_o, 2);
        lock_up("first");
        check("locked_loop", loop_en_o, 1);

        // Unlock counter cleared by an in-tolerance sample
        for (int i = 0; i < 3; i++) begin
            send_sample(5, 1'b1);
            check("unlock_partial", state_o, 3);
        end
        send_sample(1, 1'b1);
        check("unlock_cleared", state_o, 3);
        for (int i = 0; i < 4; i++) begin
            send_sample(-3, 1'b1);
            check("unlock_state", state_o, (i < 3) ? 3 : 2);
            check("unlock_lock", lock_o, (i < 3) ? 1 : 0);
        end

        // Positive saturation forces re-acquisition
        lock_up("relock1");
        saturate("sat_pos", 127);

        // Random target with noise, then negative saturation
        run_sar(1'b0, int'($urandom_range(0, 255)), 3, sar_res);
        lock_up("relock2");
        saturate("sat_neg", -128);
        run_sar(1'b0, int'($urandom_range(0, 255)), 4, sar_res);

        // Enable dropped on a decision cycle discards the decision
        go_idle();
        start_search();
        for (int i = 0; i < AVG_SAMPLES - 1; i++) begin
            send_sample(int'($urandom_range(0, 200)) - 100, 1'b1);
        end
        send_sample(int'($urandom_range(0, 200)) - 100, 1'b0);
        check_outs("drop_on_decision", 0, 0, 0, 0);
        start_search();

        // Reset in LOCKED alongside a valid sample
        run_sar(1'b0, int'($urandom_range(0, 255)), 2, sar_res);
        lock_up("final");
        @(negedge clk);
        reset_i       = 1'b1;
        error_valid_i = 1'b1;
        error_i       = 8'd127;
        @(negedge clk);
        reset_i       = 1'b0;
        error_valid_i = 1'b0;
        exp_relock    = 0;
        check_outs("reset_locked", 0, 0, 0, 0);
        enable_i = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
